// File: rtl/elastic_delay_pipe.sv
// DEPTH-stage, WIDTH-bit elastic delay pipeline with per-stage valid bits,
// valid/ready handshakes on both sides, synchronous flush and registered occupancy.
module elastic_delay_pipe #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                           sys_clock,
    input  logic                           sys_reset_n,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] up_d [DEPTH];
    logic             accept;
    logic             emit;

    // Ready chain flattened: a stage may load if it or any stage downstream is
    // empty, or the consumer takes the head word; avoids a self-referencing vector.
    always_comb begin
        rdy = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            rdy[k] = out_ready;
            for (int unsigned j = k; j < DEPTH; j++) begin
                if (!v[j]) rdy[k] = 1'b1;
            end
        end
    end

    always_comb begin
        up_v    = '0;
        up_d    = '{default: '0};
        up_v[0] = in_valid;
        up_d[0] = in_data;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            up_v[k] = v[k-1];
            up_d[k] = d[k-1];
        end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            v         <= '0;
            occupancy <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) d[k] <= '0;
        end else if (flush) begin
            // Data registers keep their contents; only the valid bits are dropped.
            v         <= '0;
            occupancy <= '0;
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    v[k] <= up_v[k];
                    if (up_v[k]) d[k] <= up_d[k];
                end
            end
            occupancy <= occupancy + OCC_W'(accept) - OCC_W'(emit);
        end
    end

endmodule

// File: tb/tb_elastic_delay_pipe.sv
// Directed self-checking bench for elastic_delay_pipe (WIDTH=2, DEPTH=4).
module tb_elastic_delay_pipe;

    logic       sys_clock = 1'b0;
    logic       sys_reset_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_data;
    logic [2:0] occupancy;

    int checks   = 0;
    int failures = 0;

    elastic_delay_pipe #(.WIDTH(2), .DEPTH(4)) dut (
        .sys_clock  (sys_clock),
        .sys_reset_n(sys_reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge sys_clock);
        #1;
    endtask

    initial begin
        sys_reset_n = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 2'd0;
        out_ready   = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occ", occupancy, 0);
        #3 sys_reset_n = 1'b1;

        // 1: fill, then drop reset mid-cycle with in_valid=1, in_data=3 held
        in_valid = 1'b1;
        in_data  = 2'd3;
        repeat (4) tick();
        chk("s1_full_occ", occupancy, 4);
        chk("s1_full_out_valid", out_valid, 1);
        chk("s1_full_out_data", out_data, 3);
        #2 sys_reset_n = 1'b0;
        #1;
        chk("s1_async_out_valid", out_valid, 0);
        chk("s1_async_out_data", out_data, 0);
        chk("s1_async_occ", occupancy, 0);
        chk("s1_async_in_ready", in_ready, 1);
        in_valid = 1'b0;
        #1 sys_reset_n = 1'b1;

        // 2: stream 0..3 with out_ready=1
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 2'd0; tick(); chk("s2_e0_occ", occupancy, 1);
        in_data   = 2'd1; tick(); chk("s2_e1_occ", occupancy, 2);
        in_data   = 2'd2; tick(); chk("s2_e2_occ", occupancy, 3);
        chk("s2_e2_out_valid", out_valid, 0);
        in_data   = 2'd3; tick();
        in_valid  = 1'b0;
        chk("s2_e3_out_valid", out_valid, 1);
        chk("s2_e3_out_data", out_data, 0);
        chk("s2_e3_occ", occupancy, 4);
        tick(); chk("s2_e4_out_data", out_data, 1); chk("s2_e4_occ", occupancy, 3);
        tick(); chk("s2_e5_out_data", out_data, 2); chk("s2_e5_occ", occupancy, 2);
        tick(); chk("s2_e6_out_data", out_data, 3); chk("s2_e6_occ", occupancy, 1);
        tick(); chk("s2_e7_out_valid", out_valid, 0); chk("s2_e7_occ", occupancy, 0);

        // 3: backpressure, offer 1,2,3,0,1
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 2'd1; #1 chk("s3_rdy_w0", in_ready, 1); tick();
        in_data = 2'd2; #1 chk("s3_rdy_w1", in_ready, 1); tick();
        in_data = 2'd3; #1 chk("s3_rdy_w2", in_ready, 1); tick();
        in_data = 2'd0; #1 chk("s3_rdy_w3", in_ready, 1); tick();
        in_data = 2'd1; #1 chk("s3_rdy_w4_full", in_ready, 0);
        chk("s3_full_occ", occupancy, 4);
        chk("s3_full_head", out_data, 1);
        tick();
        chk("s3_stall_occ", occupancy, 4);
        chk("s3_stall_head", out_data, 1);
        out_ready = 1'b1;
        #1 chk("s3_rdy_release", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("s3_d1", out_data, 2); chk("s3_occ1", occupancy, 4);
        tick(); chk("s3_d2", out_data, 3); chk("s3_occ2", occupancy, 3);
        tick(); chk("s3_d3", out_data, 0); chk("s3_occ3", occupancy, 2);
        tick(); chk("s3_d4", out_data, 1); chk("s3_occ4", occupancy, 1);
        tick(); chk("s3_empty", out_valid, 0); chk("s3_occ5", occupancy, 0);

        // 4: bubble collapse
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 2'd3;
        tick();
        in_valid  = 1'b0;
        tick();
        tick();
        in_valid  = 1'b1;
        in_data   = 2'd2;
        tick();
        in_valid  = 1'b0;
        tick();
        tick();
        chk("s4_occ", occupancy, 2);
        chk("s4_out_valid", out_valid, 1);
        chk("s4_out_data", out_data, 3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("s4_pulse_out_data", out_data, 2);
        chk("s4_pulse_occ", occupancy, 1);
        out_ready = 1'b1;
        tick();
        chk("s4_drained_occ", occupancy, 0);

        // 5: full pass-through
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 2'd1; tick();
        in_data = 2'd3; tick();
        in_data = 2'd0; tick();
        in_data = 2'd1; tick();
        chk("s5_full_occ", occupancy, 4);
        out_ready = 1'b1;
        in_data   = 2'd2;
        #1 chk("s5_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("s5_occ_hold", occupancy, 4);
        chk("s5_d1", out_data, 3);
        tick(); chk("s5_d2", out_data, 0); chk("s5_occ2", occupancy, 3);
        tick(); chk("s5_d3", out_data, 1); chk("s5_occ3", occupancy, 2);
        tick(); chk("s5_d4", out_data, 2); chk("s5_v4", out_valid, 1);
        tick(); chk("s5_empty", out_valid, 0); chk("s5_occ5", occupancy, 0);

        // 6: flush with occupancy 3 and a head word offered to the consumer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 2'd1; tick();
        in_data = 2'd2; tick();
        in_data = 2'd3; tick();
        in_valid = 1'b0;
        tick();
        chk("s6_pre_occ", occupancy, 3);
        chk("s6_pre_out_valid", out_valid, 1);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 2'd0;
        out_ready = 1'b1;
        #1 chk("s6_flush_in_ready", in_ready, 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("s6_post_out_valid", out_valid, 0);
        chk("s6_post_occ", occupancy, 0);
        in_valid = 1'b1;
        in_data  = 2'd2;
        tick();
        in_valid = 1'b0;
        chk("s6_lat_e0_occ", occupancy, 1);
        tick();
        tick();
        chk("s6_lat_e2_out_valid", out_valid, 0);
        tick();
        chk("s6_lat_e3_out_valid", out_valid, 1);
        chk("s6_lat_e3_out_data", out_data, 2);
        tick();
        chk("s6_lat_e4_occ", occupancy, 0);
        chk("s6_lat_e4_out_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
